set_level_driver: RTL and testbench
===================================

SET_LEVEL_DRIVER -- requirements
Module: set_level_driver

Interface
REQ-001 SHALL have parameter SET_SIZE, default 5: number of driven signals.
REQ-002 SHALL have parameter SET_WIDTH, default 32: width of each driven signal.
REQ-003 SHALL have parameter DUR_WIDTH, default 16: width of the pulse-duration field.
REQ-004 SHALL have parameter INIT_VALUE, default 0 (SET_WIDTH bits): reset and release value of every signal.
REQ-005 SHALL use a single clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-008 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-009 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-010 SHALL have port cmd_op, input, 2 bits: 0 = SET, 1 = PULSE, 2 = RELEASE, 3 = reserved.
REQ-011 SHALL have port cmd_idx, input, $clog2(SET_SIZE) bits (minimum 1): target signal index.
REQ-012 SHALL have port cmd_data, input, SET_WIDTH bits: level to drive.
REQ-013 SHALL have port cmd_dur, input, DUR_WIDTH bits: pulse length in cycles.
REQ-014 SHALL have port set_signals, output, SET_SIZE*SET_WIDTH bits: driven levels; signal i occupies bits [i*SET_WIDTH +: SET_WIDTH].
REQ-015 SHALL have port busy, output, 1 bit: a command is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse when a command is rejected.

Function
REQ-018 SHALL implement FSM states IDLE, APPLY, HOLD, DONE, and all outputs SHALL be registered or decoded from state only.
REQ-019 SHALL drive cmd_ready = 1 only in IDLE with rst low; a command SHALL be accepted on a rising edge where cmd_valid && cmd_ready.
REQ-020 On accept, the block SHALL latch op, idx, data and dur, then go IDLE -> APPLY; busy SHALL be 1 in APPLY, HOLD and DONE.
REQ-021 In APPLY, if cmd_idx >= SET_SIZE or op == 3, the block SHALL leave set_signals unchanged, pulse err for one cycle, and go to DONE.
REQ-022 In APPLY with SET, the block SHALL write signal[idx] <= data and go to DONE.
REQ-023 In APPLY with RELEASE, the block SHALL write signal[idx] <= INIT_VALUE and go to DONE.
REQ-024 In APPLY with PULSE, the block SHALL save the old signal[idx], write data, load counter <= max(dur,1)-1, and go to HOLD.
REQ-025 In HOLD, if counter == 0 the block SHALL restore signal[idx] <= saved value and go to DONE; otherwise it SHALL decrement counter.
REQ-026 A PULSE of dur = N (N >= 1) SHALL show data on signal[idx] for exactly N cycles; dur = 0 SHALL behave as dur = 1.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE; err, when asserted, SHALL coincide with the APPLY-to-DONE cycle, not with done.
REQ-028 Latency: SET/RELEASE accepted at edge k SHALL update the output at edge k+1, done SHALL be high between k+2 and k+3, and cmd_ready SHALL be 1 again after edge k+3.
REQ-029 The block SHALL ignore cmd_valid while cmd_ready = 0; the command source SHALL hold the command until accepted.
REQ-030 Signals not targeted by a command SHALL never change.
REQ-031 The counter SHALL never wrap; a dur of all-ones SHALL give 2^DUR_WIDTH-1 cycles.

Reset
REQ-032 While rst = 1 at a clock edge, every signal SHALL become INIT_VALUE, the state SHALL go to IDLE, and the counter and saved value SHALL clear.
REQ-033 While rst = 1, cmd_ready, busy, done and err SHALL be 0.
REQ-034 Reset during HOLD SHALL drive signal[idx] to INIT_VALUE, not the saved value, and no done SHALL follow.
REQ-035 Reset asserted on the same edge as an accept SHALL discard the command.

Verification
REQ-036 A bench SHALL cover: SET idx=2, data=0xA5A5_0001 after reset -> signal 2 = 0xA5A5_0001 one edge later, done one cycle, other signals = 0.
REQ-037 A bench SHALL cover: signal 1 = 0x10, then PULSE idx=1, data=0xFF, dur=3 -> 0xFF for exactly 3 cycles, then 0x10, then done.
REQ-038 A bench SHALL cover: PULSE dur=0 -> data held for exactly 1 cycle.
REQ-039 A bench SHALL cover: cmd_idx=5 with SET_SIZE=5, or op=3 -> err one cycle, done one cycle, set_signals unchanged.
REQ-040 A bench SHALL cover: cmd_valid held through a PULSE dur=4 -> the second command is accepted only after done, none lost or duplicated.
REQ-041 A bench SHALL cover: rst pulsed in mid-HOLD of a PULSE on signal 0 -> all signals = INIT_VALUE next edge, no done, cmd_ready = 1 after rst falls.

Source files
------------

// File: rtl/set_level_driver.sv
// Purpose: drives SET_SIZE registered levels, updated by SET / PULSE / RELEASE commands.
// Latency: accept at edge k, level written at k+1, done high k+2..k+3, ready again after k+3 (PULSE adds dur cycles).
// Backpressure: cmd_ready is high only while idle; the source holds its command until it is accepted.
module set_level_driver #(
    parameter int                   SET_SIZE   = 5,
    parameter int                   SET_WIDTH  = 32,
    parameter int                   DUR_WIDTH  = 16,
    parameter logic [SET_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                  IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [IDX_W-1:0]              cmd_idx,
    input  logic [SET_WIDTH-1:0]          cmd_data,
    input  logic [DUR_WIDTH-1:0]          cmd_dur,
    output logic [SET_SIZE*SET_WIDTH-1:0] set_signals,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_SET     = 2'd0;
    localparam logic [1:0] OP_PULSE   = 2'd1;
    localparam logic [1:0] OP_RELEASE = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    // One extra bit so the range check also works when SET_SIZE is a power of two.
    localparam logic [IDX_W:0] SIZE_L = (IDX_W+1)'(SET_SIZE);

    state_e                          state_q, state_d;
    logic [1:0]                      op_q, op_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [SET_WIDTH-1:0]            data_q, data_d;
    logic [DUR_WIDTH-1:0]            dur_q, dur_d;
    logic [DUR_WIDTH-1:0]            cnt_q, cnt_d;
    logic [SET_WIDTH-1:0]            saved_q, saved_d;
    logic [SET_SIZE*SET_WIDTH-1:0]   sig_q, sig_d;
    logic                            err_q, err_d;
    logic                            done_q, done_d;

    logic                            wr_en;
    logic [SET_WIDTH-1:0]            wr_val;
    logic [SET_WIDTH-1:0]            cur_val;
    logic                            cmd_bad;

    // Current level of the latched target; an out-of-range index reads back zero and is never used.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < SET_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_val = sig_q[i*SET_WIDTH +: SET_WIDTH];
            end
        end
    end

    // Reject commands aimed past the last signal or carrying the reserved opcode.
    always_comb begin
        cmd_bad = ({1'b0, idx_q} >= SIZE_L) || (op_q == OP_RSVD);
    end

    // Next-state, command latching and level-write decisions.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        saved_d = saved_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_val  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                // Reset already forces the state register, so being here means ready is high.
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    idx_d   = cmd_idx;
                    data_d  = cmd_data;
                    dur_d   = cmd_dur;
                    state_d = ST_APPLY;
                end
            end

            ST_APPLY: begin
                if (cmd_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    unique case (op_q)
                        OP_SET: begin
                            wr_en   = 1'b1;
                            wr_val  = data_q;
                            state_d = ST_DONE;
                        end
                        OP_RELEASE: begin
                            wr_en   = 1'b1;
                            wr_val  = INIT_VALUE;
                            state_d = ST_DONE;
                        end
                        OP_PULSE: begin
                            // The level is shown while the counter runs down to zero, so it
                            // must start at dur-1; a zero duration is treated as one cycle.
                            saved_d = cur_val;
                            wr_en   = 1'b1;
                            wr_val  = data_q;
                            cnt_d   = (dur_q == '0) ? '0 : dur_q - DUR_WIDTH'(1);
                            state_d = ST_HOLD;
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    wr_en   = 1'b1;
                    wr_val  = saved_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - DUR_WIDTH'(1);
                end
            end

            ST_DONE: begin
                // First cycle here carries err (if any); the second carries done.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Apply a single write to the targeted slot; every other slot keeps its level.
    always_comb begin
        sig_d = sig_q;
        if (wr_en) begin
            for (int i = 0; i < SET_SIZE; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sig_d[i*SET_WIDTH +: SET_WIDTH] = wr_val;
                end
            end
        end
    end

    // State and datapath registers; reset wins over any command presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
            saved_q <= '0;
            sig_q   <= {SET_SIZE{INIT_VALUE}};
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            saved_q <= saved_d;
            sig_q   <= sig_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Outputs come from registers or the state only, all gated low while reset is held.
    always_comb begin
        set_signals = sig_q;
        cmd_ready   = (state_q == ST_IDLE) && !rst;
        busy        = (state_q != ST_IDLE) && !rst;
        done        = done_q && !rst;
        err         = err_q && !rst;
    end

endmodule

// File: tb/tb_set_level_driver.sv
// Purpose: randomized and directed checking of set_level_driver against a per-cycle timeline model.
// Latency: every command is tracked from its accept edge until cmd_ready returns.
// Backpressure: commands are only presented while the block is idle, except the held-valid case.
module tb_set_level_driver;

    localparam int SZ  = 5;
    localparam int W   = 32;
    localparam int DW  = 16;
    localparam int VW  = SZ * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [2:0]    cmd_idx;
    logic [W-1:0]  cmd_data;
    logic [DW-1:0] cmd_dur;
    logic [VW-1:0] set_signals;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdl [SZ];

    set_level_driver dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_idx     (cmd_idx),
        .cmd_data    (cmd_data),
        .cmd_dur     (cmd_dur),
        .set_signals (set_signals),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected output vector: the model levels, optionally with one slot overridden.
    function automatic logic [VW-1:0] pack_mdl(input int over_idx, input logic [W-1:0] over_val);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < SZ; i++) begin
            v[i*W +: W] = (i == over_idx) ? over_val : mdl[i];
        end
        return v;
    endfunction

    // Called right after the accept edge. Cycle t is sampled after edge k+t.
    task automatic track(input logic [1:0] op, input int idx, input logic [W-1:0] data, input int dur,
                         input bit keep, input logic [1:0] nop, input int nidx,
                         input logic [W-1:0] ndata, input int ndur);
        bit ok;
        bit pls;
        int n;
        int d;
        int oi;
        logic [W-1:0] newv;
        logic [W-1:0] ov;
        ok   = (idx < SZ) && (op != 2'd3);
        pls  = ok && (op == 2'd1);
        n    = (dur == 0) ? 1 : dur;
        d    = pls ? n : 0;
        newv = (op == 2'd2) ? '0 : data;
        for (int t = 0; t <= d + 3; t++) begin
            @(negedge clk);
            oi = -1;
            ov = '0;
            if (ok && t >= 1) begin
                if (pls) begin
                    if (t <= n) begin
                        oi = idx;
                        ov = data;
                    end
                end else begin
                    oi = idx;
                    ov = newv;
                end
            end
            chk($sformatf("sig op=%0d idx=%0d t=%0d", op, idx, t), set_signals, pack_mdl(oi, ov));
            chk($sformatf("busy t=%0d", t), VW'(busy), VW'(t < d + 3));
            chk($sformatf("ready t=%0d", t), VW'(cmd_ready), VW'(t >= d + 3));
            chk($sformatf("done t=%0d", t), VW'(done), VW'(t == d + 2));
            chk($sformatf("err t=%0d", t), VW'(err), VW'(!ok && t == 1));
            if (t == 0) begin
                if (keep) begin
                    cmd_op   = nop;
                    cmd_idx  = 3'(nidx);
                    cmd_data = ndata;
                    cmd_dur  = DW'(ndur);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        if (ok && !pls) mdl[idx] = newv;
    endtask

    task automatic send(input logic [1:0] op, input int idx, input logic [W-1:0] data, input int dur);
        cmd_op    = op;
        cmd_idx   = 3'(idx);
        cmd_data  = data;
        cmd_dur   = DW'(dur);
        cmd_valid = 1'b1;
        chk("ready before accept", VW'(cmd_ready), VW'(1));
        @(posedge clk);
        track(op, idx, data, dur, 1'b0, 2'd0, 0, '0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle sig", set_signals, pack_mdl(-1, '0));
            chk("idle busy", VW'(busy), VW'(0));
            chk("idle ready", VW'(cmd_ready), VW'(1));
            chk("idle done", VW'(done), VW'(0));
            chk("idle err", VW'(err), VW'(0));
        end
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < SZ; i++) mdl[i] = '0;
    endtask

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [1:0]   rop;
        int           ridx;
        logic [W-1:0] rdata;
        int           rdur;

        clear_mdl();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_idx   = '0;
        cmd_data  = '0;
        cmd_dur   = '0;

        // Reset state, sampled while reset is still held.
        repeat (3) @(negedge clk);
        chk("rst sig", set_signals, pack_mdl(-1, '0));
        chk("rst ready", VW'(cmd_ready), VW'(0));
        chk("rst busy", VW'(busy), VW'(0));
        chk("rst done", VW'(done), VW'(0));
        chk("rst err", VW'(err), VW'(0));
        rst = 1'b0;
        idle(2);

        // SET into slot 2 right after reset.
        send(2'd0, 2, 32'hA5A5_0001, 0);
        // Slot 1 at 0x10, then a 3-cycle pulse of 0xFF.
        send(2'd0, 1, 32'h0000_0010, 0);
        send(2'd1, 1, 32'h0000_00FF, 3);
        // Zero duration behaves as one cycle.
        send(2'd1, 3, 32'h1234_5678, 0);
        // Rejected commands: index past the end, and the reserved opcode.
        send(2'd0, 5, 32'hDEAD_0005, 0);
        send(2'd3, 0, 32'hDEAD_0003, 0);
        send(2'd1, 7, 32'hDEAD_0007, 4);
        idle(1);

        // Valid held through a 4-cycle pulse; the next command waits for ready.
        cmd_op    = 2'd1;
        cmd_idx   = 3'd3;
        cmd_data  = 32'h0000_0033;
        cmd_dur   = 16'd4;
        cmd_valid = 1'b1;
        @(posedge clk);
        track(2'd1, 3, 32'h0000_0033, 4, 1'b1, 2'd0, 4, 32'h0000_4444, 0);
        @(posedge clk);
        track(2'd0, 4, 32'h0000_4444, 0, 1'b0, 2'd0, 0, '0, 0);
        idle(5);

        // RELEASE returns a slot to the initial level.
        send(2'd2, 2, 32'hFFFF_FFFF, 0);
        idle(1);

        // Randomized commands, mostly valid, with short idle gaps.
        for (int c = 0; c < 80; c++) begin
            rop   = 2'($urandom_range(0, 3));
            ridx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            rdata = $urandom;
            rdur  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 40)) : int'($urandom_range(0, 4));
            send(rop, ridx, rdata, rdur);
            idle(int'($urandom_range(0, 2)));
        end

        // Longest pulse: all-ones duration must not wrap the counter.
        send(2'd1, 4, 32'hDEAD_BEEF, 65535);
        idle(1);

        // Reset in the middle of a pulse on slot 0.
        send(2'd0, 0, 32'h0000_0077, 0);
        cmd_op    = 2'd1;
        cmd_idx   = 3'd0;
        cmd_data  = 32'h0000_C0DE;
        cmd_dur   = 16'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold sig", set_signals, pack_mdl(0, 32'h0000_C0DE));
        @(negedge clk);
        chk("hold busy", VW'(busy), VW'(1));
        rst = 1'b1;
        clear_mdl();
        @(negedge clk);
        chk("midhold rst sig", set_signals, pack_mdl(-1, '0));
        chk("midhold rst busy", VW'(busy), VW'(0));
        chk("midhold rst ready", VW'(cmd_ready), VW'(0));
        chk("midhold rst done", VW'(done), VW'(0));
        chk("midhold rst err", VW'(err), VW'(0));
        rst = 1'b0;
        idle(6);

        // Reset on the same edge as a presented command discards it.
        send(2'd0, 1, 32'h0000_0099, 0);
        cmd_op    = 2'd0;
        cmd_idx   = 3'd1;
        cmd_data  = 32'h0000_0BAD;
        cmd_dur   = 16'd0;
        cmd_valid = 1'b1;
        rst       = 1'b1;
        clear_mdl();
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        chk("rst+cmd sig", set_signals, pack_mdl(-1, '0));
        chk("rst+cmd busy", VW'(busy), VW'(0));
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
